// File: rtl/logica_control_pkg.sv
// Shared types and constants for the logica_control transaction-path controller.
package logica_control_pkg;

    typedef enum logic [2:0] {
        StReset,
        StInit,
        StIdle,
        StActive,
        StError
    } state_e;

    localparam int unsigned DefMfDepth = 4;
    localparam int unsigned DefVcDepth = 16;
    localparam int unsigned DefDDepth  = 4;

    // Word fields: bit5 picks the VC, bit4 picks the destination D FIFO.
    localparam int unsigned VC_BIT   = 5;
    localparam int unsigned DEST_BIT = 4;

    // A margin at or above the depth saturates, so the FIFO always looks almost full.
    function automatic logic almost_full(input int unsigned count,
                                         input int unsigned depth,
                                         input int unsigned thr);
        if (thr >= depth) begin
            return 1'b1;
        end
        return count >= (depth - thr);
    endfunction

endpackage

// File: rtl/logica_control_if.sv
// FIFO-side status and strobe bundle between the controller (master) and datapath (slave).
interface logica_control_if;

    logic       push;
    logic       pop_D0;
    logic       pop_D1;
    logic [2:0] mf_count;
    logic [4:0] vc0_count;
    logic [4:0] vc1_count;
    logic [2:0] d0_count;
    logic [2:0] d1_count;
    logic [5:0] head_MF;
    logic [5:0] head_VC0;
    logic [5:0] head_VC1;
    logic       Pausa_MF;
    logic       pop_MF;
    logic       pop_VC0;
    logic       pop_VC1;

    modport master (
        input  push, pop_D0, pop_D1,
        input  mf_count, vc0_count, vc1_count, d0_count, d1_count,
        input  head_MF, head_VC0, head_VC1,
        output Pausa_MF, pop_MF, pop_VC0, pop_VC1
    );

    modport slave (
        output push, pop_D0, pop_D1,
        output mf_count, vc0_count, vc1_count, d0_count, d1_count,
        output head_MF, head_VC0, head_VC1,
        input  Pausa_MF, pop_MF, pop_VC0, pop_VC1
    );

endinterface

// File: rtl/logica_control_vc_arbiter.sv
// VC0/VC1 grant arbiter: strict VC0 priority, or round-robin when VC_RR_EN is defined.
module vc_arbiter (
`ifdef VC_RR_EN
    input  logic clk,
    input  logic reset_L,
    input  logic clear,
`endif
    input  logic elig0,
    input  logic elig1,
    output logic gnt0,
    output logic gnt1
);

`ifdef VC_RR_EN
    // ptr_q = 0 prefers VC0, 1 prefers VC1; only consulted when both are eligible.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt0  = elig0 && (!elig1 || !ptr_q);
        gnt1  = elig1 && (!elig0 || ptr_q);
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = 1'b0;
        end else if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt0 = elig0;
        gnt1 = elig1 && !elig0;
    end
`endif

endmodule

// File: rtl/logica_control.sv
// Master control FSM for the MF -> VC -> D transaction path.
// Optional VC_RR_EN selects round-robin VC arbitration instead of VC0 priority.
module logica_control
    import logica_control_pkg::*;
#(
    parameter int unsigned MF_DEPTH = DefMfDepth,
    parameter int unsigned VC_DEPTH = DefVcDepth,
    parameter int unsigned D_DEPTH  = DefDDepth
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic [1:0]              umbralMF,
    input  logic [3:0]              umbralVC0,
    input  logic [3:0]              umbralVC1,
    input  logic [1:0]              umbralD0,
    input  logic [1:0]              umbralD1,
    logica_control_if.master        bus,
    output logic                    idle_out,
    output logic                    active_out,
    output logic                    error_out
);

    state_e     state_q, state_d;
    logic [1:0] thr_mf_q;
    logic [3:0] thr_vc0_q, thr_vc1_q;
    logic [1:0] thr_d0_q, thr_d1_q;

    logic flow_en, all_zero, err_det, load_thr;
    logic af_mf, af_vc0, af_vc1, af_d0, af_d1;
    logic elig0, elig1, gnt0, gnt1;

    // Payload bits travel through the datapath untouched.
    logic unused_head;
    assign unused_head = ^{bus.head_MF, bus.head_VC0, bus.head_VC1};

    assign flow_en  = (state_q == StIdle) || (state_q == StActive);
    assign load_thr = (state_q == StInit) && init;

    assign all_zero = (bus.mf_count == '0) && (bus.vc0_count == '0) && (bus.vc1_count == '0) &&
                      (bus.d0_count == '0) && (bus.d1_count == '0);

    assign err_det = (bus.push && (32'(bus.mf_count) == MF_DEPTH)) ||
                     (bus.pop_D0 && (bus.d0_count == '0)) ||
                     (bus.pop_D1 && (bus.d1_count == '0));

    always_comb begin
        af_mf  = almost_full(32'(bus.mf_count), MF_DEPTH, 32'(thr_mf_q));
        af_vc0 = almost_full(32'(bus.vc0_count), VC_DEPTH, 32'(thr_vc0_q));
        af_vc1 = almost_full(32'(bus.vc1_count), VC_DEPTH, 32'(thr_vc1_q));
        af_d0  = almost_full(32'(bus.d0_count), D_DEPTH, 32'(thr_d0_q));
        af_d1  = almost_full(32'(bus.d1_count), D_DEPTH, 32'(thr_d1_q));
    end

    always_comb begin
        elig0 = flow_en && (bus.vc0_count != '0) &&
                !(bus.head_VC0[DEST_BIT] ? af_d1 : af_d0);
        elig1 = flow_en && (bus.vc1_count != '0) &&
                !(bus.head_VC1[DEST_BIT] ? af_d1 : af_d0);
    end

`ifdef VC_RR_EN
    logic arb_clear;
    assign arb_clear = (state_q == StInit);
`endif

    vc_arbiter u_vc_arbiter (
`ifdef VC_RR_EN
        .clk     (clk),
        .reset_L (reset_L),
        .clear   (arb_clear),
`endif
        .elig0   (elig0),
        .elig1   (elig1),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    assign bus.Pausa_MF = flow_en ? af_mf : 1'b1;
    assign bus.pop_MF   = flow_en && (bus.mf_count != '0) &&
                          !(bus.head_MF[VC_BIT] ? af_vc1 : af_vc0);
    assign bus.pop_VC0  = gnt0;
    assign bus.pop_VC1  = gnt1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset: state_d = StInit;
            StInit: begin
                if (!init) begin
                    state_d = all_zero ? StIdle : StActive;
                end
            end
            StIdle, StActive: begin
                if (err_det) begin
                    state_d = StError;
                end else if (init) begin
                    state_d = StInit;
                end else begin
                    state_d = all_zero ? StIdle : StActive;
                end
            end
            StError: begin
                if (init) begin
                    state_d = StInit;
                end
            end
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= StReset;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_out   <= (state_d == StIdle);
            active_out <= (state_d == StActive);
            error_out  <= (state_d == StError);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            thr_mf_q  <= '0;
            thr_vc0_q <= '0;
            thr_vc1_q <= '0;
            thr_d0_q  <= '0;
            thr_d1_q  <= '0;
        end else if (load_thr) begin
            thr_mf_q  <= umbralMF;
            thr_vc0_q <= umbralVC0;
            thr_vc1_q <= umbralVC1;
            thr_d0_q  <= umbralD0;
            thr_d1_q  <= umbralD1;
        end
    end

endmodule

// File: tb/tb_logica_control.sv
// Self-checking bench for logica_control; expected output vectors are queued as stimulus is driven.
module tb_logica_control;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic [1:0] umbralMF;
    logic [3:0] umbralVC0;
    logic [3:0] umbralVC1;
    logic [1:0] umbralD0;
    logic [1:0] umbralD1;
    logic       idle_out;
    logic       active_out;
    logic       error_out;

    logica_control_if bus ();

    logica_control dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .init       (init),
        .umbralMF   (umbralMF),
        .umbralVC0  (umbralVC0),
        .umbralVC1  (umbralVC1),
        .umbralD0   (umbralD0),
        .umbralD1   (umbralD1),
        .bus        (bus),
        .idle_out   (idle_out),
        .active_out (active_out),
        .error_out  (error_out)
    );

`ifdef VC_RR_EN
    localparam bit Rr = 1'b1;
`else
    localparam bit Rr = 1'b0;
`endif

    // {Pausa_MF, pop_MF, pop_VC0, pop_VC1, idle_out, active_out, error_out}
    logic [6:0] obs;
    assign obs = {bus.Pausa_MF, bus.pop_MF, bus.pop_VC0, bus.pop_VC1,
                  idle_out, active_out, error_out};

    logic [6:0] exp_q[$];
    string      name_q[$];
    logic [6:0] e;
    string      n;
    int         checks = 0;
    int         errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.push      = 1'b0;
        bus.pop_D0    = 1'b0;
        bus.pop_D1    = 1'b0;
        bus.mf_count  = '0;
        bus.vc0_count = '0;
        bus.vc1_count = '0;
        bus.d0_count  = '0;
        bus.d1_count  = '0;
        bus.head_MF   = '0;
        bus.head_VC0  = '0;
        bus.head_VC1  = '0;
    endtask

    // From IDLE/ACTIVE/ERROR: one edge to enter INIT, one to load, one to leave.
    task automatic do_init(input logic [1:0] mf, input logic [3:0] vc0, input logic [3:0] vc1,
                           input logic [1:0] d0, input logic [1:0] d1);
        @(negedge clk);
        init = 1'b1;
        umbralMF = mf; umbralVC0 = vc0; umbralVC1 = vc1; umbralD0 = d0; umbralD1 = d1;
        @(negedge clk);
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        init = 1'b0;
        umbralMF = 2'd0; umbralVC0 = 4'd0; umbralVC1 = 4'd0; umbralD0 = 2'd0; umbralD1 = 2'd0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        exp_q.push_back(7'b1000000); name_q.push_back("reset_hold");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        reset_L = 1'b1;
        @(negedge clk);
        init = 1'b1; umbralMF = 2'd1;
        exp_q.push_back(7'b1000000); name_q.push_back("reset_to_init");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        @(negedge clk);
        init = 1'b0;
        exp_q.push_back(7'b1000000); name_q.push_back("init_hold");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        @(negedge clk);
        exp_q.push_back(7'b0000100); name_q.push_back("init_to_idle");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
    endtask

    task automatic test_mf_pause();
        @(negedge clk);
        bus.mf_count = 3'd3;
        exp_q.push_back(7'b1100100); name_q.push_back("mf_pause_af");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        @(negedge clk);
        bus.mf_count = 3'd2;
        exp_q.push_back(7'b0100010); name_q.push_back("mf_pause_clear");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_mf_routing();
        do_init(2'd1, 4'd0, 4'd2, 2'd0, 2'd0);
        bus.head_MF = 6'b111011; bus.mf_count = 3'd1; bus.vc1_count = 5'd15;
        exp_q.push_back(7'b0001100); name_q.push_back("route_vc1_af");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        @(negedge clk);
        bus.vc1_count = 5'd13;
        exp_q.push_back(7'b0101010); name_q.push_back("route_vc1_ok");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_thresholds();
        do_init(2'd3, 4'd0, 4'd0, 2'd0, 2'd0);
        // Changing the margin outside INIT must have no effect.
        umbralMF = 2'd0; bus.mf_count = 3'd1;
        exp_q.push_back(7'b1100100); name_q.push_back("thr_mf3_af");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        @(negedge clk);
        bus.mf_count = 3'd0;
        exp_q.push_back(7'b0000010); name_q.push_back("thr_mf_empty");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_arbitration();
        logic g;
        do_init(2'd0, 4'd0, 4'd0, 2'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            bus.vc0_count = 5'd3; bus.vc1_count = 5'd3;
            g = Rr && (i % 2 == 1);
            exp_q.push_back({2'b00, !g, g, (i == 0), (i != 0), 1'b0});
            name_q.push_back($sformatf("arb_cycle%0d", i));
            #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        end
    endtask

    task automatic test_d_backpressure();
        @(negedge clk);
        bus.head_VC0 = 6'b011010; bus.d1_count = 3'd4;
        exp_q.push_back(7'b0001010); name_q.push_back("bp_d1_full");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        @(negedge clk);
        bus.d1_count = 3'd3;
        exp_q.push_back(7'b0010010); name_q.push_back("bp_release");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_errors();
        do_init(2'd1, 4'd0, 4'd0, 2'd0, 2'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.push = 1'b1; bus.mf_count = 3'd4;
            end else begin
                bus.pop_D1 = 1'b1; bus.d1_count = 3'd0;
            end
            @(negedge clk);
            bus.push = 1'b0; bus.pop_D1 = 1'b0; bus.mf_count = 3'd0; bus.vc0_count = 5'd3;
            exp_q.push_back(7'b1000001); name_q.push_back($sformatf("err%0d_entry", k));
            #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
            @(negedge clk);
            init = 1'b1;
            exp_q.push_back(7'b1000001); name_q.push_back($sformatf("err%0d_sticky", k));
            #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
            @(negedge clk);
            init = 1'b0; bus.vc0_count = 5'd0;
            exp_q.push_back(7'b1000000); name_q.push_back($sformatf("err%0d_init", k));
            #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
            @(negedge clk);
            exp_q.push_back(7'b0000100); name_q.push_back($sformatf("err%0d_idle", k));
            #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        end
    endtask

    task automatic test_reset_mid_transfer();
        @(negedge clk);
        bus.vc0_count = 5'd3;
        @(negedge clk);
        exp_q.push_back(7'b0010010); name_q.push_back("mid_active");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        reset_L = 1'b0;
        exp_q.push_back(7'b1000000); name_q.push_back("mid_async_reset");
        #1 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        @(negedge clk);
        bus.vc0_count = 5'd0; reset_L = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.mf_count = 3'd3;
        exp_q.push_back(7'b0100100); name_q.push_back("mid_thr_cleared");
        #2 e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: outputs %b, expected %b", n, obs, e); end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_mf_pause();
        test_mf_routing();
        test_thresholds();
        test_arbitration();
        test_d_backpressure();
        test_errors();
        test_reset_mid_transfer();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/logica_control.md
# logica_control

Master control FSM for the PCIe-style transaction path (main FIFO → VC0/VC1 FIFOs → D0/D1 FIFOs). It latches the programmable almost-full thresholds during init and reports `idle_out`, `active_out` and `error_out`. It drives `Pausa_MF` back to the upstream source and generates the pop strobes that move words MF→VC and VC→D. Words are 6 bits: bit5 selects the VC, bit4 selects the destination D, and bits 3:0 are payload.

## Interface
Parameters:
- `MF_DEPTH`, default 4: main FIFO depth.
- `VC_DEPTH`, default 16: depth of each VC FIFO.
- `D_DEPTH`, default 4: depth of each D FIFO.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset_L`, in, 1: asynchronous, active-low reset.
- `init`, in, 1: enter INIT state and load thresholds.
- `umbralMF`, in, 2: main FIFO almost-full margin.
- `umbralVC0`, in, 4: VC0 almost-full margin.
- `umbralVC1`, in, 4: VC1 almost-full margin.
- `umbralD0`, in, 2: D0 almost-full margin.
- `umbralD1`, in, 2: D1 almost-full margin.
- `push`, in, 1: upstream push into MF (monitored for overflow).
- `pop_D0`, in, 1: downstream pop of D0 (monitored for underflow).
- `pop_D1`, in, 1: downstream pop of D1 (monitored for underflow).
- `mf_count`, in, 3: current MF occupancy.
- `vc0_count`, in, 5: current VC0 occupancy.
- `vc1_count`, in, 5: current VC1 occupancy.
- `d0_count`, in, 3: current D0 occupancy.
- `d1_count`, in, 3: current D1 occupancy.
- `head_MF`, in, 6: word at the MF head.
- `head_VC0`, in, 6: word at the VC0 head.
- `head_VC1`, in, 6: word at the VC1 head.
- `Pausa_MF`, out, 1: upstream must not push.
- `pop_MF`, out, 1: pop MF; the datapath pushes the word into VC[`head_MF`[5]].
- `pop_VC0`, out, 1: pop VC0; the datapath pushes the word into D[`head_VC0`[4]].
- `pop_VC1`, out, 1: pop VC1; the datapath pushes the word into D[`head_VC1`[4]].
- `idle_out`, out, 1: state is IDLE.
- `active_out`, out, 1: state is ACTIVE.
- `error_out`, out, 1: state is ERROR.

## Operation
States are RESET, INIT, IDLE, ACTIVE and ERROR.

State transitions:
- `reset_L`=0 forces RESET immediately, asynchronously.
- RESET goes to INIT on the first clock edge with `reset_L`=1.
- INIT loads all five threshold registers on every edge while `init`=1. When `init`=0 it goes to IDLE if all counts are 0, otherwise to ACTIVE.
- IDLE and ACTIVE re-evaluate every edge:
  - if an error is detected, go to ERROR;
  - else if `init`=1, go to INIT;
  - else if all five counts are 0, go to IDLE;
  - else go to ACTIVE.
- ERROR is sticky. Only `init`=1 (next state INIT) or reset leaves it.

Error conditions, sampled on the edge:
- `push` && `mf_count`==MF_DEPTH (overflow).
- `pop_D0` && `d0_count`==0 (underflow).
- `pop_D1` && `d1_count`==0 (underflow).

Almost-full, for each FIFO X: af_X = (count_X >= DEPTH_X − thr_X), using zero-extended unsigned arithmetic. A threshold of 0 means af = full. A threshold of DEPTH or more saturates, so af is always 1.

Flow control, evaluated only in IDLE or ACTIVE. In every other state all pops are 0 and `Pausa_MF`=1.
- `Pausa_MF` = af_MF.
- `pop_MF` = (`mf_count`≠0) && !af_VC[`head_MF`[5]].
- VC eligibility: eligible_k = (vck_count≠0) && !af_D[head_VCk[4]].
- VC arbitration: at most one of `pop_VC0`/`pop_VC1` per cycle. By default VC0 has strict priority.
- Occupancy counts are the pre-update values. Pops and pushes in the same cycle are not credited.
- No bubble requirement: one transfer per stage per cycle when eligible.

## Timing
- Reset values:
  - state RESET;
  - all thresholds 0;
  - `Pausa_MF`=1;
  - `pop_MF`, `pop_VC0`, `pop_VC1` = 0;
  - `idle_out`, `active_out`, `error_out` = 0;
  - round-robin pointer = VC0.
- `idle_out`, `active_out` and `error_out` are registered decodes of the state. `error_out` rises one cycle after the offending edge.
- The pop outputs and `Pausa_MF` are combinational from state, thresholds and the count/head inputs, so they respond in the same cycle. They carry no path from `push`, `pop_D0` or `pop_D1`.
- Threshold changes take effect the cycle after the INIT edge that loads them. Thresholds are ignored outside INIT.
- If reset asserts mid-transfer, pops drop to 0 immediately and thresholds are cleared.

## Configuration
- `VC_RR_EN` defined: round-robin arbitration between VC0 and VC1.
  - A one-bit pointer selects the preferred VC when both are eligible.
  - The pointer toggles to the other VC after each grant.
  - Reset and INIT clear the pointer to VC0.
- `VC_RR_EN` undefined: VC0 strict priority and no pointer register.

## Structure
- Shared package holds:
  - the state enum (RESET, INIT, IDLE, ACTIVE, ERROR);
  - the MF/VC/D depth constants;
  - the word field positions (VC_BIT=5, DEST_BIT=4).
- One sub-module, `vc_arbiter`, takes the two eligibility inputs and produces the two grants. It contains the `VC_RR_EN` pointer.

## Test plan
- **Reset/init:** hold `reset_L`=0 for 2 cycles, release, pulse `init` for 1 cycle with `umbralMF`=1. Expected: RESET→INIT→IDLE, then `idle_out`=1 and `Pausa_MF`=0.
- **MF pause:** with `umbralMF`=1, drive `mf_count`=3. Expected: `Pausa_MF`=1 in the same cycle. Drive `mf_count`=2; expected: `Pausa_MF`=0.
- **MF routing:** `head_MF`=6'b111011 with `vc1_count`=15 and `umbralVC1`=2. Expected: `pop_MF`=0. Set `vc1_count`=13; expected: `pop_MF`=1.
- **Arbitration:** both VCs nonempty and D0 not full.
  - Default build: `pop_VC0`=1 on every cycle.
  - `VC_RR_EN` build: `pop_VC0` and `pop_VC1` alternate, starting with VC0.
- **D backpressure:** `head_VC0`=6'b011010 with `d1_count`=4. Expected: VC0 is ineligible and VC1 (destined for D0) is granted.
- **Errors:** `push`=1 with `mf_count`=4. Expected: `error_out`=1 on the next cycle and all pops 0. This holds while `init`=0; pulsing `init`=1 returns through INIT to IDLE. Repeat with `pop_D1`=1 and `d1_count`=0 for the same result.
